// File: rtl/fifo_drain_stream.sv
// rtl/fifo_drain_stream.sv - drains an upstream FIFO (1-cycle read latency) into a valid/ready stream
// Optional feature macro: FIFO_DRAIN_BEAT_CNT_EN (adds 16-bit beat_count output).
module fifo_drain_stream #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             drain_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_DRAIN_BEAT_CNT_EN
  ,
  output logic [15:0]      beat_count
`endif
);

  // Two-entry skid buffer plus a flag for the read issued last cycle.
  logic [WIDTH-1:0] buf_q [2];
  logic             head_q;
  logic             tail_q;
  logic [1:0]       count_q;
  logic             inflight_q;

  logic             pop;
  logic [2:0]       count_d;

  assign pop = m_valid & m_ready;

  // Occupancy after this cycle: the inflight word lands, a popped word leaves.
  // A read may be issued only if the word it returns will still have a slot.
  assign count_d = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Read request is gated by resetn so nothing is requested while held in reset.
  assign fifo_rd_en = resetn & drain_en & ~fifo_empty & (count_d < 3'd2);

  assign m_valid = (count_q != 2'd0);
  assign m_data  = m_valid ? buf_q[head_q] : '0;

  // Pointer, occupancy and inflight tracking; reset discards everything held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      count_q    <= count_d[1:0];
      if (inflight_q) begin
        tail_q <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

  // Capture the returning FIFO word at the tail; contents need no reset since
  // m_data is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (inflight_q) begin
      buf_q[tail_q] <= fifo_data;
    end
  end

`ifdef FIFO_DRAIN_BEAT_CNT_EN
  logic [15:0] beat_q;

  // Free-running count of delivered beats, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_q <= 16'h0000;
    end else if (pop) begin
      beat_q <= beat_q + 16'h0001;
    end
  end

  assign beat_count = beat_q;
`endif

endmodule
